// File: rtl/sd_pkg.sv
// Shared types and defaults for the SD playback scheduler.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_STOP     = 3'd3,
        ST_WAIT_CMP = 3'd4,
        ST_DONE     = 3'd5,
        ST_GAP      = 3'd6
    } sd_state_t;

    localparam int SD_ID_W    = 8;
    localparam int SD_GAP_CYC = 16;

endpackage

// File: rtl/sd_rr_arb.sv
// Combinational picker over the pending requesters: round-robin from rr_ptr,
// or lowest-index-first when SD_PLAY_SCHED_PRIO_EN is defined.
module sd_rr_arb #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  pending,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] grant,
    output logic             any
);

    logic [IDX_W:0] sum;

    always_comb begin
        grant = '0;
        sum   = '0;
        any   = |pending;
`ifdef SD_PLAY_SCHED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pending[i]) grant = IDX_W'(i);
        end
`else
        // Scan backwards so the last hit is the one closest to rr_ptr.
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NREQ)) sum = sum - (IDX_W+1)'(NREQ);
            if (pending[sum[IDX_W-1:0]]) grant = sum[IDX_W-1:0];
        end
`endif
    end

endmodule

// File: rtl/sd_play_sched.sv
// Grants the single SDFeed engine to NREQ requesters, drives note_on/off and
// inserts a drain gap between plays. SD_PLAY_SCHED_PRIO_EN: fixed priority + preemption.
module sd_play_sched
    import sd_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ID_W    = SD_ID_W,
    parameter int GAP_CYC = SD_GAP_CYC,
    parameter int TMO_W   = 24
) (
    input  logic                     clk96m,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_start,
    input  logic [NREQ-1:0]          req_stop,
    input  logic [NREQ*ID_W-1:0]     req_id,
    output logic [ID_W-1:0]          sd_id,
    output logic                     sd_note_on,
    output logic                     sd_note_off,
    input  logic                     sd_completed,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  active_idx,
    output logic [NREQ-1:0]          done,
    output logic                     tmo_err
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    // Watchdog fires on the edge where the counter would become all-ones.
    localparam logic [TMO_W-1:0] WD_END = ~TMO_W'(1);

    sd_state_t                   state;
    logic [NREQ-1:0]             pending, pend_nxt;
    logic [NREQ-1:0][ID_W-1:0]   id_reg;
    logic [IDX_W-1:0]            rr_ptr;
    logic [IDX_W-1:0]            grant;
    logic                        any;
    logic [TMO_W-1:0]            wd;
    logic [GAP_W-1:0]            gap_cnt;
    logic                        preempt;

`ifdef SD_PLAY_SCHED_PRIO_EN
    logic [NREQ-1:0] lower;
    assign rr_ptr = '0;
    always_comb begin
        lower = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) < active_idx) lower[i] = 1'b1;
        end
        preempt = |(req_start & lower);
    end
`else
    assign preempt = 1'b0;
`endif

    sd_rr_arb #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .grant   (grant),
        .any     (any)
    );

    // A start arriving on the granted index in the grant cycle re-queues it.
    always_comb begin
        pend_nxt = pending;
        if (state == ST_IDLE && any) pend_nxt[grant] = 1'b0;
        pend_nxt = (pend_nxt | req_start) & ~req_stop;
    end

    always_ff @(posedge clk96m) begin
        if (rst) begin
            state       <= ST_IDLE;
            pending     <= '0;
            id_reg      <= '0;
            active_idx  <= '0;
            sd_id       <= '0;
            sd_note_on  <= 1'b0;
            sd_note_off <= 1'b0;
            done        <= '0;
            tmo_err     <= 1'b0;
            busy        <= 1'b0;
            wd          <= '0;
            gap_cnt     <= '0;
`ifndef SD_PLAY_SCHED_PRIO_EN
            rr_ptr      <= '0;
`endif
        end else begin
            pending <= pend_nxt;
            for (int i = 0; i < NREQ; i++) begin
                if (req_start[i]) id_reg[i] <= req_id[i*ID_W +: ID_W];
            end
            sd_note_on  <= 1'b0;
            sd_note_off <= 1'b0;
            done        <= '0;
            tmo_err     <= 1'b0;
            case (state)
                ST_IDLE: if (any) begin
                    state      <= ST_START;
                    active_idx <= grant;
                    sd_id      <= id_reg[grant];
                    sd_note_on <= 1'b1;
                    busy       <= 1'b1;
`ifndef SD_PLAY_SCHED_PRIO_EN
                    rr_ptr     <= (grant == IDX_W'(NREQ - 1)) ? '0 : grant + IDX_W'(1);
`endif
                end
                ST_START: state <= ST_PLAY;
                ST_PLAY: begin
                    if (sd_completed) begin
                        state              <= ST_DONE;
                        done[active_idx]   <= 1'b1;
                    end else if (req_stop[active_idx] || preempt) begin
                        state       <= ST_STOP;
                        sd_note_off <= 1'b1;
                    end
                end
                ST_STOP: begin
                    state <= ST_WAIT_CMP;
                    wd    <= '0;
                end
                ST_WAIT_CMP: begin
                    if (sd_completed) begin
                        state            <= ST_DONE;
                        done[active_idx] <= 1'b1;
                    end else if (wd == WD_END) begin
                        state   <= ST_GAP;
                        tmo_err <= 1'b1;
                        gap_cnt <= '0;
                    end else begin
                        wd <= wd + TMO_W'(1);
                    end
                end
                ST_DONE: begin
                    state   <= ST_GAP;
                    gap_cnt <= '0;
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
